fetch_unit: RTL and testbench

Instruction fetch sequencer for the MIPS core: the supplier side of the decode path. Holds the PC and fetches one word per instruction from instruction memory over a req/ack handshake. Presents the captured instruction (op/funct/immediate fields) to the decoder and datapath with a valid qualifier. Consumes the decoder's `pcsrc`/`jump` results to compute the next PC.

---
 rtl/mips_pkg.sv | 27 ++
 rtl/pc_nextsel.sv | 32 +++
 rtl/fetch_unit.sv | 138 +++++++++++++
 tb/tb_fetch_unit.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS fetch path.
package mips_pkg;

  // Fetch sequencer states; ERR is only reachable when the timeout logic is built in.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    EXEC = 2'd2,
    ERR  = 2'd3
  } fetch_state_t;

  // Instruction field positions.
  localparam int OP_MSB      = 31;
  localparam int OP_LSB      = 26;
  localparam int FUNCT_MSB   = 5;
  localparam int FUNCT_LSB   = 0;
  localparam int JTARGET_MSB = 25;
  localparam int JTARGET_LSB = 0;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  // Instruction addresses are always word aligned.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/pc_nextsel.sv
// Combinational next-PC selection: sequential, branch and jump targets.
module pc_nextsel
  import mips_pkg::*;
(
  input  logic [31:0]                  pc,
  input  logic [JTARGET_MSB:JTARGET_LSB] jtarget,
  input  logic [31:0]                  signimm,
  input  logic                         pcsrc,
  input  logic                         jump,
  output logic [31:0]                  pcplus4,
  output logic [31:0]                  next_pc
);

  logic [31:0] branch_target;
  logic [31:0] jump_target;

  // All arithmetic wraps modulo 2^32; overflow past the top of memory is silent.
  assign pcplus4       = pc + 32'd4;
  assign branch_target = pcplus4 + (signimm << 2);
  assign jump_target   = {pcplus4[31:28], jtarget, 2'b00};

  // Jump has priority over a taken branch when the decoder raises both.
  always_comb begin
    next_pc = pcplus4;
    if (jump) begin
      next_pc = jump_target;
    end else if (pcsrc) begin
      next_pc = branch_target;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch sequencer: owns the PC, fetches one word per instruction
// over a req/ack handshake and presents it to the decoder with a valid flag.
// Optional macro FETCH_TIMEOUT_EN adds an ack wait counter and a sticky
// error state; without it REQ waits for ack indefinitely.
module fetch_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC       = DEFAULT_RESET_PC,
  parameter int          TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic [31:0] pc,
  output logic [31:0] pcplus4,
  input  logic        stall,
  input  logic        pcsrc,
  input  logic        jump,
  input  logic [31:0] signimm,
  output logic        fetch_err
);

  localparam logic [31:0] RESET_PC_ALIGNED = word_align(RESET_PC);

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  instr_q, instr_d;
  logic         req_q, req_d;
  logic         valid_q, valid_d;
  logic [31:0]  next_pc;

`ifdef FETCH_TIMEOUT_EN
  localparam logic [15:0] TIMEOUT_LIMIT = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0]  wait_q, wait_d;
  logic         err_q, err_d;
`else
  logic         unused_timeout;
  assign unused_timeout = (TIMEOUT_CYCLES != 0);
`endif

  pc_nextsel u_pc_nextsel (
    .pc      (pc_q),
    .jtarget (instr_q[JTARGET_MSB:JTARGET_LSB]),
    .signimm (signimm),
    .pcsrc   (pcsrc),
    .jump    (jump),
    .pcplus4 (pcplus4),
    .next_pc (next_pc)
  );

  // Next-state logic; outputs are decoded from the next state so they come straight from flops.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
`ifdef FETCH_TIMEOUT_EN
    wait_d  = wait_q;
`endif
    unique case (state_q)
      IDLE: state_d = REQ;
      REQ: begin
        if (imem_ack) begin
          instr_d = imem_rdata;
          state_d = EXEC;
        end
`ifdef FETCH_TIMEOUT_EN
        else if (wait_q == TIMEOUT_LIMIT) begin
          state_d = ERR;
        end else begin
          wait_d = wait_q + 16'd1;
        end
`endif
      end
      EXEC: begin
        if (!stall) begin
          pc_d    = next_pc;
          state_d = REQ;
        end
      end
`ifdef FETCH_TIMEOUT_EN
      ERR: state_d = ERR;
`else
      ERR: state_d = IDLE;
`endif
      default: state_d = IDLE;
    endcase
`ifdef FETCH_TIMEOUT_EN
    if (state_d == REQ && state_q != REQ) begin
      wait_d = 16'd0;
    end
    err_d   = (state_d == ERR);
`endif
    req_d   = (state_d == REQ);
    valid_d = (state_d == EXEC);
  end

  // State and output registers with synchronous reset; any pending request is dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC_ALIGNED;
      instr_q <= 32'h0;
      req_q   <= 1'b0;
      valid_q <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
      wait_q  <= 16'd0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      req_q   <= req_d;
      valid_q <= valid_d;
`ifdef FETCH_TIMEOUT_EN
      wait_q  <= wait_d;
      err_q   <= err_d;
`endif
    end
  end

  assign imem_req    = req_q;
  assign imem_addr   = pc_q;
  assign instr       = instr_q;
  assign instr_valid = valid_q;
  assign pc          = pc_q;
`ifdef FETCH_TIMEOUT_EN
  assign fetch_err   = err_q;
`else
  assign fetch_err   = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: stimulus pushes expected fetch addresses
// and executed instructions, a monitor pops and compares them.
module tb_fetch_unit;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } exec_t;

  logic        clk;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic        instr_valid;
  logic [31:0] pc;
  logic [31:0] pcplus4;
  logic        stall;
  logic        pcsrc;
  logic        jump;
  logic [31:0] signimm;
  logic        fetch_err;

  int          checks = 0;
  int          failures = 0;
  logic [31:0] expPc = 32'h0;
  logic [31:0] addrQ[$];
  exec_t       execQ[$];
  logic        prevReq = 1'b0;

  fetch_unit #(
    .RESET_PC       (32'h0000_0000),
    .TIMEOUT_CYCLES (4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .instr       (instr),
    .instr_valid (instr_valid),
    .pc          (pc),
    .pcplus4     (pcplus4),
    .stall       (stall),
    .pcsrc       (pcsrc),
    .jump        (jump),
    .signimm     (signimm),
    .fetch_err   (fetch_err)
  );

  // Free-running clock, rising edge at 5 + 10k.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case something wedges the stimulus process.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=running expected=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
    end
  endtask

  task automatic checkResetValues();
    checkOutput("rst_imem_req", {31'b0, imem_req}, 32'd0);
    checkOutput("rst_imem_addr", imem_addr, 32'h0);
    checkOutput("rst_instr", instr, 32'h0);
    checkOutput("rst_instr_valid", {31'b0, instr_valid}, 32'd0);
    checkOutput("rst_pc", pc, 32'h0);
    checkOutput("rst_pcplus4", pcplus4, 32'h4);
    checkOutput("rst_fetch_err", {31'b0, fetch_err}, 32'd0);
  endtask

  // Waits (bounded) for the DUT to be requesting; returns 1 if it is.
  task automatic waitForReq(output bit ok);
    int n = 0;
    while (imem_req !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    ok = (imem_req === 1'b1);
    if (!ok) begin
      checks++;
      failures++;
      $display("[TB] FAIL req_wait actual=%b expected=1", imem_req);
    end
  endtask

  // Serves one fetch with a given ack latency, then holds EXEC for the given stall count.
  task automatic applyStimulus(input int waits, input logic [31:0] data, input int stalls,
                               input logic br, input logic jp, input logic [31:0] imm,
                               input logic [31:0] nextPc);
    bit ok;
    waitForReq(ok);
    if (!ok) return;
    for (int i = 0; i < waits; i++) begin
      imem_ack = 1'b0;
      @(negedge clk);
      checkOutput("req_hold", {31'b0, imem_req}, 32'd1);
      checkOutput("addr_hold", imem_addr, expPc);
    end
    for (int s = 0; s <= stalls; s++) execQ.push_back('{pc: expPc, instr: data});
    imem_ack   = 1'b1;
    imem_rdata = data;
    stall      = (stalls > 0);
    pcsrc      = br;
    jump       = jp;
    signimm    = imm;
    @(negedge clk);
    imem_ack = 1'b0;
    for (int s = 1; s <= stalls; s++) begin
      @(negedge clk);
      if (s == stalls) stall = 1'b0;
    end
    expPc = nextPc;
    addrQ.push_back(nextPc);
  endtask

  // Holds reset for two edges, checks reset values, releases and checks first request timing.
  task automatic doReset();
    reset    = 1'b1;
    imem_ack = 1'b0;
    stall    = 1'b0;
    pcsrc    = 1'b0;
    jump     = 1'b0;
    repeat (2) @(negedge clk);
    checkResetValues();
    expPc = 32'h0;
    addrQ.push_back(32'h0);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("first_req", {31'b0, imem_req}, 32'd1);
  endtask

  // Monitor: pops the scoreboard on every executable cycle and every new request.
  always @(negedge clk) begin
    exec_t       e;
    logic [31:0] a;
    if (instr_valid === 1'b1) begin
      if (execQ.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL exec_unexpected actual=pc_%h expected=none", pc);
      end else begin
        e = execQ.pop_front();
        checkOutput("exec_pc", pc, e.pc);
        checkOutput("exec_instr", instr, e.instr);
        checkOutput("exec_pcplus4", pcplus4, e.pc + 32'd4);
      end
    end
    if (imem_req === 1'b1 && !prevReq) begin
      if (addrQ.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL req_unexpected actual=addr_%h expected=none", imem_addr);
      end else begin
        a = addrQ.pop_front();
        checkOutput("fetch_addr", imem_addr, a);
      end
    end
    prevReq = (imem_req === 1'b1);
  end

  initial begin
    bit ok;
    reset      = 1'b1;
    imem_ack   = 1'b0;
    imem_rdata = 32'h0;
    stall      = 1'b0;
    pcsrc      = 1'b0;
    jump       = 1'b0;
    signimm    = 32'h0;

    doReset();
    // Same-cycle acks: 0 -> 4 -> 8.
    applyStimulus(0, 32'h2001_0005, 0, 1'b0, 1'b0, 32'h0, 32'h0000_0004);
    applyStimulus(0, 32'h0000_0020, 0, 1'b0, 1'b0, 32'h0, 32'h0000_0008);
    // Three wait cycles before ack.
    applyStimulus(3, 32'h8C22_0004, 0, 1'b0, 1'b0, 32'h0, 32'h0000_000C);
    applyStimulus(0, 32'h0043_1820, 0, 1'b0, 1'b0, 32'h0, 32'h0000_0010);
    // Taken branch at 0x10 with offset -2 words: 0x14 - 8 = 0x0C.
    applyStimulus(0, 32'h1000_FFFE, 0, 1'b1, 1'b0, 32'hFFFF_FFFE, 32'h0000_000C);
    // Three stall cycles in EXEC, then the normal advance.
    applyStimulus(1, 32'hAC22_0008, 3, 1'b0, 1'b0, 32'h0, 32'h0000_0010);

    // Reset while requesting at 0x10; an ack during/after reset is ignored.
    waitForReq(ok);
    reset = 1'b1;
    @(negedge clk);
    checkResetValues();
    imem_ack   = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    expPc = 32'h0;
    addrQ.push_back(32'h0);
    reset = 1'b0;
    @(negedge clk);
    imem_ack = 1'b0;
    checkOutput("late_ack_instr", instr, 32'h0);
    checkOutput("late_ack_valid", {31'b0, instr_valid}, 32'd0);

    // Jump at 0: target 0x40 << 2 = 0x100.
    applyStimulus(0, 32'h0800_0040, 0, 1'b0, 1'b1, 32'h0, 32'h0000_0100);
    // Jump and branch together: jump to 0x200, not branch target 0x118.
    applyStimulus(0, 32'h0800_0080, 0, 1'b1, 1'b1, 32'h0000_0005, 32'h0000_0200);
    // Backward branch at 0x200 by -0x82 words: 0x204 - 0x208 wraps to 0xFFFFFFFC.
    applyStimulus(0, 32'h1000_FF7E, 0, 1'b1, 1'b0, 32'hFFFF_FF7E, 32'hFFFF_FFFC);
    // Sequential from the top word wraps to 0.
    applyStimulus(0, 32'h0000_0000, 0, 1'b0, 1'b0, 32'h0, 32'h0000_0000);
    applyStimulus(2, 32'h2002_0001, 0, 1'b0, 1'b0, 32'h0, 32'h0000_0004);

    waitForReq(ok);
    @(negedge clk);
    checkOutput("addr_queue_drained", addrQ.size(), 32'd0);
    checkOutput("exec_queue_drained", execQ.size(), 32'd0);
    checkOutput("no_fetch_err", {31'b0, fetch_err}, 32'd0);

`ifdef FETCH_TIMEOUT_EN
    // No ack at all: four REQ cycles, then sticky error until reset.
    doReset();
    imem_ack = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("tmo_not_yet", {31'b0, fetch_err}, 32'd0);
    @(negedge clk);
    checkOutput("tmo_err", {31'b0, fetch_err}, 32'd1);
    checkOutput("tmo_req", {31'b0, imem_req}, 32'd0);
    checkOutput("tmo_valid", {31'b0, instr_valid}, 32'd0);
    imem_ack = 1'b1;
    repeat (3) @(negedge clk);
    imem_ack = 1'b0;
    checkOutput("tmo_err_sticky", {31'b0, fetch_err}, 32'd1);
    checkOutput("tmo_req_held", {31'b0, imem_req}, 32'd0);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checkResetValues();
    reset = 1'b0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
